// File: rtl/alu_result_stage.sv
// Registered ALU result select with zero/overflow/illegal-op flags into a 2-entry valid/ready buffer.
// Latency 1 cycle from accepted push to out_valid; throughput 1 op/cycle while out_ready is high.
// Backpressure: in_ready drops when both entries are full; optional parity output under ALU_RESULT_PARITY_EN.
module alu_result_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] and_r,
    input  logic [WIDTH-1:0] or_r,
    input  logic [WIDTH-1:0] xor_r,
    input  logic [WIDTH-1:0] nor_r,
    input  logic [WIDTH-1:0] add_r,
    input  logic [WIDTH-1:0] sub_r,
    input  logic             add_ovf,
    input  logic             sub_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             err
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic             parity
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             zero;
        logic             ovf;
        logic             err;
`ifdef ALU_RESULT_PARITY_EN
        logic             par;
`endif
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           new_entry;
    entry_t           head;
    logic [CNT_W-1:0] count;
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] sel_res;
    logic             sel_ovf;
    logic             sel_err;

    always_comb begin
        sel_res = '0;
        sel_ovf = 1'b0;
        sel_err = 1'b0;
        case (op)
            3'b000: sel_res = and_r;
            3'b001: sel_res = or_r;
            3'b010: sel_res = xor_r;
            3'b011: sel_res = nor_r;
            3'b100: begin
                sel_res = add_r;
                sel_ovf = add_ovf;
            end
            3'b101: begin
                sel_res = sub_r;
                sel_ovf = sub_ovf;
            end
            // Signed less-than: true sign of a-b is the raw sign corrected by overflow.
            3'b110: sel_res = {{(WIDTH-1){1'b0}}, sub_r[WIDTH-1] ^ sub_ovf};
            default: sel_err = 1'b1;
        endcase
    end

    always_comb begin
        new_entry      = '0;
        new_entry.res  = sel_res;
        new_entry.zero = (sel_res == '0);
        new_entry.ovf  = sel_ovf;
        new_entry.err  = sel_err;
`ifdef ALU_RESULT_PARITY_EN
        new_entry.par  = ^sel_res;
`endif
    end

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset: contents are masked until count says they are live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= new_entry;
        end
    end

    assign head   = mem[rd_ptr];
    assign result = out_valid ? head.res  : '0;
    assign zero   = out_valid ? head.zero : 1'b0;
    assign ovf    = out_valid ? head.ovf  : 1'b0;
    assign err    = out_valid ? head.err  : 1'b0;
`ifdef ALU_RESULT_PARITY_EN
    assign parity = out_valid ? head.par  : 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: vector table plus back-pressure, streaming and reset sequences.
module tb_alu_result_stage;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   op = 3'b000;
    logic [W-1:0] and_r = '0, or_r = '0, xor_r = '0, nor_r = '0, add_r = '0, sub_r = '0;
    logic         add_ovf = 1'b0, sub_ovf = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic         zero, ovf, err;
`ifdef ALU_RESULT_PARITY_EN
    logic         parity;
`endif

    alu_result_stage #(.WIDTH(W), .DEPTH(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .and_r(and_r), .or_r(or_r), .xor_r(xor_r), .nor_r(nor_r), .add_r(add_r), .sub_r(sub_r),
        .add_ovf(add_ovf), .sub_ovf(sub_ovf), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .ovf(ovf), .err(err)
`ifdef ALU_RESULT_PARITY_EN
        , .parity(parity)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] v;
        logic        aovf;
        logic        sovf;
        logic [31:0] e_res;
        logic        e_zero;
        logic        e_ovf;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ovf;
        logic        err;
    } exp_t;

    int    n_cmp = 0;
    int    n_err = 0;
    bit    mon_en = 1'b0;
    exp_t  sb[$];
    exp_t  cur;
    exp_t  mon_e;
    vec_t  tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [31:0] v, input logic a, input logic s,
                                input logic [31:0] er, input logic ez, input logic eo, input logic ee);
        vec_t t;
        t.op = o; t.v = v; t.aovf = a; t.sovf = s;
        t.e_res = er; t.e_zero = ez; t.e_ovf = eo; t.e_err = ee;
        return t;
    endfunction

    // Distinct decoys on every unit so a wrong select shows up as a wrong result.
    task automatic drive(input vec_t t);
        and_r = 32'hDEAD_0000; or_r = 32'h0000_BEEF; xor_r = 32'h1234_5678;
        nor_r = 32'hFFFF_0000; add_r = 32'h0F0F_0F0F; sub_r = 32'hF0F0_F0F0;
        case (t.op)
            3'd0: and_r = t.v;
            3'd1: or_r  = t.v;
            3'd2: xor_r = t.v;
            3'd3: nor_r = t.v;
            3'd4: add_r = t.v;
            3'd5, 3'd6: sub_r = t.v;
            default: ;
        endcase
        op = t.op; add_ovf = t.aovf; sub_ovf = t.sovf;
        cur.res = t.e_res; cur.zero = t.e_zero; cur.ovf = t.e_ovf; cur.err = t.e_err;
    endtask

    task automatic send(input vec_t t);
        bit done;
        done = 1'b0;
        drive(t);
        in_valid = 1'b1;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) chk("accept_timeout", {63'b0, in_ready}, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: pop and compare on a handshake at the head, push on accepted input.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready_vs_count", {63'b0, in_ready}, {63'b0, sb.size() != 2});
            chk("out_valid_vs_count", {63'b0, out_valid}, {63'b0, sb.size() != 0});
            if (!out_valid) chk("idle_outputs", {29'b0, result, zero, ovf, err}, 64'd0);
            if (!reset && out_valid && out_ready && sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("result", {32'b0, result}, {32'b0, mon_e.res});
                chk("zero", {63'b0, zero}, {63'b0, mon_e.zero});
                chk("ovf", {63'b0, ovf}, {63'b0, mon_e.ovf});
                chk("err", {63'b0, err}, {63'b0, mon_e.err});
`ifdef ALU_RESULT_PARITY_EN
                chk("parity", {63'b0, parity}, {63'b0, ^mon_e.res});
`endif
            end
            if (!reset && in_valid && in_ready) sb.push_back(cur);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] sv;
        tbl[0]  = mk(3'b010, 32'hA5A5_A5A5, 0, 0, 32'hA5A5_A5A5, 0, 0, 0);
        tbl[1]  = mk(3'b000, 32'h0000_0001, 0, 0, 32'h0000_0001, 0, 0, 0);
        tbl[2]  = mk(3'b001, 32'h0000_0002, 0, 0, 32'h0000_0002, 0, 0, 0);
        tbl[3]  = mk(3'b011, 32'h0000_0003, 0, 0, 32'h0000_0003, 0, 0, 0);
        tbl[4]  = mk(3'b110, 32'h8000_0000, 0, 0, 32'h0000_0001, 0, 0, 0);
        tbl[5]  = mk(3'b110, 32'h7FFF_FFFF, 0, 1, 32'h0000_0001, 0, 0, 0);
        tbl[6]  = mk(3'b101, 32'h8000_0000, 0, 1, 32'h8000_0000, 0, 1, 0);
        tbl[7]  = mk(3'b100, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 1, 0);
        tbl[8]  = mk(3'b111, 32'h0000_0005, 1, 1, 32'h0000_0000, 1, 0, 1);
        tbl[9]  = mk(3'b100, 32'h1234_5678, 0, 1, 32'h1234_5678, 0, 0, 0);
        tbl[10] = mk(3'b101, 32'h0000_0000, 1, 0, 32'h0000_0000, 1, 0, 0);
        tbl[11] = mk(3'b110, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 0, 0);
        tbl[12] = mk(3'b110, 32'h8000_0000, 0, 1, 32'h0000_0000, 1, 0, 0);
        tbl[13] = mk(3'b000, 32'hFFFF_FFFE, 0, 0, 32'hFFFF_FFFE, 0, 0, 0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        chk("rst_result", {32'b0, result}, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single op, one-cycle latency
        out_ready = 1'b1;
        send(tbl[0]);
        in_valid = 1'b0;
        @(negedge clk);
        chk("latency_out_valid", {63'b0, out_valid}, 64'd1);
        idle(2);

        // Table, back-to-back
        for (int i = 1; i < 14; i++) send(tbl[i]);
        idle(3);

        // Back-pressure: two accepted, third held
        out_ready = 1'b0;
        send(tbl[1]);
        send(tbl[2]);
        drive(tbl[3]);
        in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {63'b0, in_ready}, 64'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        send(tbl[3]);
        idle(4);

        // Streaming ADD with push and pop together at count 1
        for (int i = 0; i < 8; i++) begin
            sv = 32'h0101_0101 * (i + 1);
            send(mk(3'b100, sv, i[0], 0, sv, 0, i[0], 0));
            if (i > 0) begin
                chk("stream_out_valid", {63'b0, out_valid}, 64'd1);
                chk("stream_in_ready", {63'b0, in_ready}, 64'd1);
            end
        end
        idle(3);

        // Reset with a full buffer and a pending push
        out_ready = 1'b0;
        send(tbl[4]);
        send(tbl[6]);
        drive(tbl[9]);
        in_valid = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        idle(5);

        send(tbl[13]);
        idle(3);
        @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/alu_result_stage.md
# alu_result_stage

Registered result stage directly downstream of the 32-bit combinational ALU units (AND, OR, XOR, NOR, adder, subtractor). Each cycle it selects one unit result by opcode, derives flags (zero, overflow, illegal-op), and pushes the entry into a 2-entry output buffer with a valid/ready handshake toward the writeback stage. The buffer absorbs one cycle of writeback back-pressure without losing an accepted operation.

## Interface
Parameters:
- WIDTH, 32, datapath width; unit results and `result` are WIDTH bits.
- DEPTH, 2, buffer entries; only 2 is supported.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents an operation this cycle.
- in_ready  out  1  stage accepts this cycle; equals (count != 2).
- op  in  3  000 AND, 001 OR, 010 XOR, 011 NOR, 100 ADD, 101 SUB, 110 SLT, 111 illegal.
- and_r, or_r, xor_r, nor_r, add_r, sub_r  in  WIDTH each  combinational unit results for the current operands.
- add_ovf, sub_ovf  in  1 each  signed overflow from adder and subtractor.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream consumes head when out_valid is high.
- result  out  WIDTH  head entry result.
- zero  out  1  head result == 0.
- ovf  out  1  head signed overflow (ADD/SUB only).
- err  out  1  head opcode was 111.
- parity  out  1  even parity of head result; present only with ALU_RESULT_PARITY_EN.

## Operation
- Push: `in_valid && in_ready` at a rising edge. Pop: `out_valid && out_ready` at a rising edge.
- Selection:
  - AND, OR, XOR, NOR, ADD, SUB: corresponding unit result.
  - SLT: {WIDTH-1 zeros, sub_r[WIDTH-1] ^ sub_ovf}.
  - 111: result 0, err=1.
- Flags:
  - zero is computed on the selected result; 111 therefore gives zero=1, err=1.
  - ovf = add_ovf for ADD, sub_ovf for SUB, 0 otherwise (including SLT).
- Buffer:
  - 2-entry circular buffer with 1-bit write pointer, 1-bit read pointer and 2-bit count (0..2).
  - Pointers wrap 1→0.
  - Outputs are driven from the entry at the read pointer.
- Push and pop in the same cycle:
  - Both happen and count is unchanged.
  - Legal at count 1.
  - At count 2 no push can occur, because in_ready=0.
- Entry contents are never modified after push. A pop never alters the other entry.
- When out_valid=0, result, zero, ovf, err and parity are 0.

## Timing
- Latency 1: an operation pushed at edge N with count 0 appears with out_valid=1 after edge N.
- Throughput 1 op/cycle while out_ready=1.
- in_ready and out_valid are functions of count only, with no combinational path from in_valid or out_ready.
- Reset (synchronous): count=0, pointers=0, out_valid=0, in_ready=1, all data outputs 0.
- Reset takes priority over a simultaneous push or pop. Buffered entries are discarded, including reset mid-stream with count 2.
- in_ready is 1 in the cycle reset is deasserted.

## Configuration
- ALU_RESULT_PARITY_EN defined:
  - Each entry stores an extra bit, the XOR-reduction of the selected result.
  - `parity` port exists; 1 when the result has an odd number of ones.
- Not defined: no parity storage and no `parity` port. All other behaviour is identical.

## Test plan
- Reset then single op: XOR with xor_r=0xA5A5A5A5, out_ready=1. Expect out_valid=1 one cycle after push, result=0xA5A5A5A5, zero=0, ovf=0, err=0; with the macro defined, parity=0.
- Back-pressure: out_ready=0, three consecutive pushes (AND 0x1, OR 0x2, NOR 0x3).
  - First two accepted; in_ready=0 after the second; third held by upstream.
  - Raise out_ready: results drain in order 0x1, 0x2, then 0x3 after it is accepted.
- Simultaneous push/pop at count 1 for 8 cycles with a streaming ADD sequence: count stays 1 and results emerge in order. This exercises pointer wrap.
- SLT: sub_r=0x80000000, sub_ovf=0 → result=1. SLT: sub_r=0x7FFFFFFF, sub_ovf=1 → result=1, ovf=0. SUB with sub_ovf=1 → ovf=1.
- Illegal op 111 → result=0, zero=1, err=1.
- Reset asserted with count 2 and out_ready=0, plus in_valid=1 that cycle. Next cycle: out_valid=0, in_ready=1, and no stale entry appears afterward.
